// File: rtl/io_bridge_arbiter.sv
// Round-robin arbiter sharing the bridge slave port among NUM_REQ Avalon-MM requesters.
// Outstanding reads are tracked in an ID FIFO so returning data reaches its issuer.
module io_bridge_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int MAX_PEND = 8,
    parameter int PEND_W   = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*4-1:0]      req_byteenable,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
    output logic [NUM_REQ-1:0]        req_waitrequest,
    output logic [DATA_W-1:0]         req_readdata,
    output logic [NUM_REQ-1:0]        req_readdatavalid,
    output logic [ADDR_W-1:0]         br_address,
    output logic [3:0]                br_byteenable,
    output logic                      br_read,
    output logic                      br_write,
    output logic [DATA_W-1:0]         br_writedata,
    input  logic                      br_waitrequest,
    input  logic [DATA_W-1:0]         br_readdata,
    input  logic                      br_readdatavalid,
    output logic [PEND_W:0]           pend_count,
    output logic                      rsp_error
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    logic [ID_W-1:0]     grant_id;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     id_fifo [MAX_PEND];
    logic [PEND_W-1:0]   wr_ptr;
    logic [PEND_W-1:0]   rd_ptr;

    logic [NUM_REQ-1:0]  elig;
    logic                any_elig;
    logic [ID_W-1:0]     winner;
    logic                busy;
    logic                g_read;
    logic                g_write;
    logic                accept;
    logic                push;
    logic                pop;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_write[i] | (req_read[i] & (pend_count < (PEND_W+1)'(MAX_PEND)));
        end
    end

    // Scan downward so the nearest eligible index after rr_ptr is the last one to win.
    always_comb begin
        any_elig = 1'b0;
        winner   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (elig[(int'(rr_ptr) + k) % NUM_REQ]) begin
                any_elig = 1'b1;
                winner   = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign busy    = (state == BUSY);
    assign g_read  = req_read[grant_id];
    assign g_write = req_write[grant_id];

    always_comb begin
        br_address      = '0;
        br_byteenable   = '0;
        br_writedata    = '0;
        br_read         = 1'b0;
        br_write        = 1'b0;
        req_waitrequest = '1;
        if (busy) begin
            br_address                = req_address[int'(grant_id)*ADDR_W +: ADDR_W];
            br_byteenable             = req_byteenable[int'(grant_id)*4 +: 4];
            br_writedata              = req_writedata[int'(grant_id)*DATA_W +: DATA_W];
            br_read                   = g_read;
            br_write                  = g_write;
            req_waitrequest[grant_id] = br_waitrequest;
        end
    end

    assign accept = (br_read | br_write) & ~br_waitrequest;
    assign push   = accept & br_read;
    assign pop    = br_readdatavalid & (pend_count != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= ID_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        grant_id <= winner;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept) begin
                        rr_ptr <= grant_id;
                        state  <= IDLE;
                    end else if (!g_read && !g_write) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A read grant was only given below MAX_PEND, so a push never overflows the FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            pend_count        <= '0;
            rsp_error         <= 1'b0;
            req_readdatavalid <= '0;
            req_readdata      <= '0;
            for (int i = 0; i < MAX_PEND; i++) begin
                id_fifo[i] <= '0;
            end
        end else begin
            if (push) begin
                id_fifo[wr_ptr] <= grant_id;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                pend_count <= pend_count + 1'b1;
            end else if (pop && !push) begin
                pend_count <= pend_count - 1'b1;
            end
            if (br_readdatavalid && pend_count == '0) begin
                rsp_error <= 1'b1;
            end
            if (pop) begin
                req_readdatavalid <= NUM_REQ'(1) << id_fifo[rd_ptr];
                req_readdata      <= br_readdata;
            end else begin
                req_readdatavalid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_io_bridge_arbiter.sv
// Directed bench for io_bridge_arbiter: arbitration order, stalls, read-ID routing and reset.
module tb_io_bridge_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 32;

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic [NUM_REQ*ADDR_W-1:0] req_address = '0;
    logic [NUM_REQ*4-1:0]      req_byteenable = '1;
    logic [NUM_REQ-1:0]        req_read = '0;
    logic [NUM_REQ-1:0]        req_write = '0;
    logic [NUM_REQ*DATA_W-1:0] req_writedata = '0;
    logic [NUM_REQ-1:0]        req_waitrequest;
    logic [DATA_W-1:0]         req_readdata;
    logic [NUM_REQ-1:0]        req_readdatavalid;
    logic [ADDR_W-1:0]         br_address;
    logic [3:0]                br_byteenable;
    logic                      br_read;
    logic                      br_write;
    logic [DATA_W-1:0]         br_writedata;
    logic                      br_waitrequest = 1'b0;
    logic [DATA_W-1:0]         br_readdata = '0;
    logic                      br_readdatavalid = 1'b0;
    logic [3:0]                pend_count;
    logic                      rsp_error;

    int n_checks = 0;
    int n_pass = 0;

    io_bridge_arbiter #(
        .NUM_REQ(4), .ID_W(2), .ADDR_W(6), .DATA_W(32), .MAX_PEND(8), .PEND_W(3)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_address(req_address), .req_byteenable(req_byteenable),
        .req_read(req_read), .req_write(req_write), .req_writedata(req_writedata),
        .req_waitrequest(req_waitrequest), .req_readdata(req_readdata),
        .req_readdatavalid(req_readdatavalid),
        .br_address(br_address), .br_byteenable(br_byteenable),
        .br_read(br_read), .br_write(br_write), .br_writedata(br_writedata),
        .br_waitrequest(br_waitrequest), .br_readdata(br_readdata),
        .br_readdatavalid(br_readdatavalid),
        .pend_count(pend_count), .rsp_error(rsp_error)
    );

    // Clock and reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Inputs are driven 1 time unit after the rising edge; checks follow after another unit.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_address      = '0;
        req_read         = '0;
        req_write        = '0;
        req_writedata    = '0;
        br_waitrequest   = 1'b0;
        br_readdata      = '0;
        br_readdatavalid = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        reset_n = 1'b0;
        clear_inputs();
        tick();
        reset_n = 1'b1;
    endtask

    // Holds a read on requester idx until the bridge accepts it, then releases it.
    task automatic issue_read(input int idx, input logic [ADDR_W-1:0] addr, output bit ok);
        ok = 1'b0;
        tick();
        req_address[idx*ADDR_W +: ADDR_W] = addr;
        req_read[idx] = 1'b1;
        for (int n = 0; n < 10; n++) begin
            #1;
            if (br_read && !req_waitrequest[idx]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        req_read[idx] = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        tick();
        #1;
        n_checks++; if (req_waitrequest !== 4'hF) $display("FAIL rst_waitreq: got %h exp %h", req_waitrequest, 4'hF); else n_pass++;
        n_checks++; if (br_read !== 1'b0 || br_write !== 1'b0) $display("FAIL rst_br_rw: got %b%b exp 00", br_read, br_write); else n_pass++;
        n_checks++; if (pend_count !== 4'd0) $display("FAIL rst_pend: got %0d exp 0", pend_count); else n_pass++;
        n_checks++; if (rsp_error !== 1'b0) $display("FAIL rst_rsp_error: got %b exp 0", rsp_error); else n_pass++;
        n_checks++; if (req_readdatavalid !== 4'h0 || req_readdata !== 32'h0) $display("FAIL rst_rdata: got %h/%h exp 0/0", req_readdatavalid, req_readdata); else n_pass++;
        tick();
        reset_n = 1'b1;
        #1;
        n_checks++; if (req_waitrequest !== 4'hF) $display("FAIL rst_release_waitreq: got %h exp %h", req_waitrequest, 4'hF); else n_pass++;
    endtask

    task automatic test_single_write();
        do_reset();
        tick();
        req_address[2*ADDR_W +: ADDR_W] = 6'h05;
        req_writedata[2*DATA_W +: DATA_W] = 32'hDEADBEEF;
        req_write[2] = 1'b1;
        #1;
        n_checks++; if (br_write !== 1'b0) $display("FAIL wr_arb_cycle_br_write: got %b exp 0", br_write); else n_pass++;
        tick();
        #1;
        n_checks++; if (br_write !== 1'b1) $display("FAIL wr_br_write: got %b exp 1", br_write); else n_pass++;
        n_checks++; if (br_address !== 6'h05) $display("FAIL wr_br_address: got %h exp 05", br_address); else n_pass++;
        n_checks++; if (br_writedata !== 32'hDEADBEEF) $display("FAIL wr_br_writedata: got %h exp deadbeef", br_writedata); else n_pass++;
        n_checks++; if (req_waitrequest !== 4'b1011) $display("FAIL wr_waitreq_low: got %b exp 1011", req_waitrequest); else n_pass++;
        tick();
        req_write[2] = 1'b0;
        #1;
        n_checks++; if (br_write !== 1'b0) $display("FAIL wr_br_write_after: got %b exp 0", br_write); else n_pass++;
        n_checks++; if (req_waitrequest !== 4'hF) $display("FAIL wr_waitreq_after: got %b exp 1111", req_waitrequest); else n_pass++;
        n_checks++; if (pend_count !== 4'd0) $display("FAIL wr_pend: got %0d exp 0", pend_count); else n_pass++;
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [DATA_W-1:0]  exp_q[$];
        logic [NUM_REQ-1:0] exp_vld_q[$];
        int                 ret_cyc_q[$];
        logic [DATA_W-1:0]  ret_dat_q[$];
        int issues = 0;
        int peak = 0;
        logic [NUM_REQ-1:0] exp_gnt;
        logic [DATA_W-1:0]  d;
        do_reset();
        for (int cyc = 0; cyc < 30; cyc++) begin
            tick();
            req_read = (issues < 5) ? 4'hF : 4'h0;
            if (ret_cyc_q.size() > 0 && ret_cyc_q[0] == cyc) begin
                void'(ret_cyc_q.pop_front());
                br_readdatavalid = 1'b1;
                br_readdata = ret_dat_q.pop_front();
            end else begin
                br_readdatavalid = 1'b0;
            end
            #1;
            if (int'(pend_count) > peak) peak = int'(pend_count);
            if (req_readdatavalid !== 4'h0) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rr_unexpected_pulse: got %b exp none", req_readdatavalid);
                end else begin
                    d = exp_q.pop_front();
                    exp_gnt = exp_vld_q.pop_front();
                    if (req_readdatavalid !== exp_gnt || req_readdata !== d)
                        $display("FAIL rr_read_route: got %b/%h exp %b/%h", req_readdatavalid, req_readdata, exp_gnt, d);
                    else n_pass++;
                end
            end
            if (br_read === 1'b1 && issues < 5) begin
                exp_gnt = 4'b0001 << exp_order[issues];
                n_checks++;
                if (~req_waitrequest !== exp_gnt) $display("FAIL rr_grant_%0d: got %b exp %b", issues, ~req_waitrequest, exp_gnt);
                else n_pass++;
                d = 32'hA0000000 | 32'(issues);
                exp_q.push_back(d);
                exp_vld_q.push_back(exp_gnt);
                ret_cyc_q.push_back(cyc + 3);
                ret_dat_q.push_back(d);
                issues++;
            end
        end
        n_checks++; if (issues != 5) $display("FAIL rr_issue_count: got %0d exp 5", issues); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL rr_missing_responses: got %0d left exp 0", exp_q.size()); else n_pass++;
        n_checks++; if (peak != 2) $display("FAIL rr_pend_peak: got %0d exp 2", peak); else n_pass++;
        n_checks++; if (pend_count !== 4'd0) $display("FAIL rr_pend_end: got %0d exp 0", pend_count); else n_pass++;
    endtask

    task automatic test_pend_cap();
        int n = 0;
        do_reset();
        tick();
        req_address[0 +: ADDR_W] = 6'h10;
        req_read[0] = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (br_read && !req_waitrequest[0]) n++;
            if (n == 8) break;
            tick();
        end
        n_checks++; if (n != 8) $display("FAIL cap_fill_reads: got %0d exp 8", n); else n_pass++;
        tick();
        req_address[1*ADDR_W +: ADDR_W] = 6'h33;
        req_write[1] = 1'b1;
        #1;
        n_checks++; if (pend_count !== 4'd8) $display("FAIL cap_pend_full: got %0d exp 8", pend_count); else n_pass++;
        tick();
        #1;
        n_checks++; if (br_write !== 1'b1 || br_read !== 1'b0) $display("FAIL cap_write_grant: got w%b r%b exp w1 r0", br_write, br_read); else n_pass++;
        n_checks++; if (br_address !== 6'h33) $display("FAIL cap_write_addr: got %h exp 33", br_address); else n_pass++;
        n_checks++; if (req_waitrequest !== 4'b1101) $display("FAIL cap_write_waitreq: got %b exp 1101", req_waitrequest); else n_pass++;
        tick();
        req_write[1] = 1'b0;
        #1;
        n_checks++; if (br_read !== 1'b0 || req_waitrequest[0] !== 1'b1) $display("FAIL cap_read_stalled: got r%b wr%b exp r0 wr1", br_read, req_waitrequest[0]); else n_pass++;
        tick();
        br_readdatavalid = 1'b1;
        br_readdata = 32'hCAFE0001;
        #1;
        n_checks++; if (br_read !== 1'b0) $display("FAIL cap_read_still_stalled: got %b exp 0", br_read); else n_pass++;
        tick();
        br_readdatavalid = 1'b0;
        #1;
        n_checks++; if (req_readdatavalid !== 4'b0001 || req_readdata !== 32'hCAFE0001) $display("FAIL cap_return: got %b/%h exp 0001/cafe0001", req_readdatavalid, req_readdata); else n_pass++;
        n_checks++; if (pend_count !== 4'd7) $display("FAIL cap_pend_after_pop: got %0d exp 7", pend_count); else n_pass++;
        tick();
        #1;
        n_checks++; if (br_read !== 1'b1 || req_waitrequest !== 4'b1110) $display("FAIL cap_ninth_read: got r%b wr%b exp r1 wr1110", br_read, req_waitrequest); else n_pass++;
        tick();
        req_read[0] = 1'b0;
        #1;
        n_checks++; if (pend_count !== 4'd8) $display("FAIL cap_pend_refill: got %0d exp 8", pend_count); else n_pass++;
    endtask

    task automatic test_bridge_stall();
        do_reset();
        tick();
        req_address[1*ADDR_W +: ADDR_W] = 6'h2A;
        req_address[2*ADDR_W +: ADDR_W] = 6'h11;
        req_read[1] = 1'b1;
        req_read[2] = 1'b1;
        br_waitrequest = 1'b1;
        #1;
        n_checks++; if (br_read !== 1'b0) $display("FAIL stall_arb_cycle: got %b exp 0", br_read); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            tick();
            #1;
            n_checks++; if (br_read !== 1'b1 || br_address !== 6'h2A) $display("FAIL stall_hold_%0d: got r%b a%h exp r1 a2a", k, br_read, br_address); else n_pass++;
            n_checks++; if (req_waitrequest !== 4'hF) $display("FAIL stall_waitreq_%0d: got %b exp 1111", k, req_waitrequest); else n_pass++;
        end
        tick();
        br_waitrequest = 1'b0;
        #1;
        n_checks++; if (req_waitrequest !== 4'b1101 || br_address !== 6'h2A) $display("FAIL stall_accept: got wr%b a%h exp 1101 a2a", req_waitrequest, br_address); else n_pass++;
        tick();
        req_read = '0;
        #1;
        n_checks++; if (pend_count !== 4'd1) $display("FAIL stall_one_push: got %0d exp 1", pend_count); else n_pass++;
        n_checks++; if (br_read !== 1'b0) $display("FAIL stall_idle_after: got %b exp 0", br_read); else n_pass++;
    endtask

    task automatic test_push_pop_same_cycle();
        bit ok;
        bit found = 1'b0;
        do_reset();
        issue_read(3, 6'h03, ok);
        n_checks++; if (!ok) $display("FAIL pp_issue_r3: got timeout exp accept"); else n_pass++;
        issue_read(1, 6'h01, ok);
        n_checks++; if (!ok) $display("FAIL pp_issue_r1: got timeout exp accept"); else n_pass++;
        issue_read(2, 6'h02, ok);
        n_checks++; if (!ok) $display("FAIL pp_issue_r2: got timeout exp accept"); else n_pass++;
        #1;
        n_checks++; if (pend_count !== 4'd3) $display("FAIL pp_pend_before: got %0d exp 3", pend_count); else n_pass++;
        tick();
        req_read[0] = 1'b1;
        for (int n = 0; n < 10; n++) begin
            #1;
            if (br_read && !req_waitrequest[0]) begin
                br_readdatavalid = 1'b1;
                br_readdata = 32'h12345678;
                found = 1'b1;
                break;
            end
            tick();
        end
        n_checks++; if (!found) $display("FAIL pp_issue_r0: got timeout exp accept"); else n_pass++;
        tick();
        req_read[0] = 1'b0;
        br_readdatavalid = 1'b0;
        #1;
        n_checks++; if (pend_count !== 4'd3) $display("FAIL pp_pend_same: got %0d exp 3", pend_count); else n_pass++;
        n_checks++; if (req_readdatavalid !== 4'b1000 || req_readdata !== 32'h12345678) $display("FAIL pp_oldest_route: got %b/%h exp 1000/12345678", req_readdatavalid, req_readdata); else n_pass++;
        tick();
        br_readdatavalid = 1'b1;
        br_readdata = 32'h0000_0B01;
        tick();
        br_readdata = 32'h0000_0B02;
        #1;
        n_checks++; if (req_readdatavalid !== 4'b0010 || req_readdata !== 32'h0000_0B01) $display("FAIL pp_route_r1: got %b/%h exp 0010/00000b01", req_readdatavalid, req_readdata); else n_pass++;
        tick();
        br_readdata = 32'h0000_0B03;
        #1;
        n_checks++; if (req_readdatavalid !== 4'b0100 || req_readdata !== 32'h0000_0B02) $display("FAIL pp_route_r2: got %b/%h exp 0100/00000b02", req_readdatavalid, req_readdata); else n_pass++;
        tick();
        br_readdatavalid = 1'b0;
        #1;
        n_checks++; if (req_readdatavalid !== 4'b0001 || req_readdata !== 32'h0000_0B03) $display("FAIL pp_route_r0: got %b/%h exp 0001/00000b03", req_readdatavalid, req_readdata); else n_pass++;
        n_checks++; if (pend_count !== 4'd0 || rsp_error !== 1'b0) $display("FAIL pp_drained: got p%0d e%b exp p0 e0", pend_count, rsp_error); else n_pass++;
    endtask

    task automatic test_reset_mid_flight();
        bit ok;
        do_reset();
        issue_read(0, 6'h01, ok);
        n_checks++; if (!ok) $display("FAIL rm_issue: got timeout exp accept"); else n_pass++;
        #1;
        n_checks++; if (pend_count !== 4'd1) $display("FAIL rm_pend_before: got %0d exp 1", pend_count); else n_pass++;
        tick();
        reset_n = 1'b0;
        #1;
        n_checks++; if (pend_count !== 4'd0) $display("FAIL rm_pend_async_clear: got %0d exp 0", pend_count); else n_pass++;
        tick();
        reset_n = 1'b1;
        tick();
        br_readdatavalid = 1'b1;
        br_readdata = 32'h0000_0055;
        tick();
        br_readdatavalid = 1'b0;
        #1;
        n_checks++; if (req_readdatavalid !== 4'h0) $display("FAIL rm_no_pulse: got %b exp 0000", req_readdatavalid); else n_pass++;
        n_checks++; if (rsp_error !== 1'b1) $display("FAIL rm_rsp_error: got %b exp 1", rsp_error); else n_pass++;
        tick();
        #1;
        n_checks++; if (rsp_error !== 1'b1 || pend_count !== 4'd0) $display("FAIL rm_error_sticky: got e%b p%0d exp e1 p0", rsp_error, pend_count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_pend_cap();
        test_bridge_stall();
        test_push_pop_same_cycle();
        test_reset_mid_flight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
